// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icode constants and the fetch-PC unit state type
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  typedef enum logic [1:0] {RUN, RET_WAIT, HALTED} pcu_state_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (push/pop in, top/count/sticky-overflow out)
module pc_ras #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_addr,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         ovf
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic full;
  assign full  = cnt_q == FULL;
  assign top   = mem_q[sp_q - PW'(1)];
  assign count = cnt_q;
  assign ovf   = ovf_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[sp_q] = push_addr;
    sp_d  = push ? sp_q + PW'(1) : pop ? sp_q - PW'(1) : sp_q;
    cnt_d = push ? (full ? cnt_q : cnt_q + (PW+1)'(1)) : (pop && cnt_q != '0) ? cnt_q - (PW+1)'(1) : cnt_q;
    ovf_d = ovf_q | (push & full);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: registered fetch PC with next-PC prediction, RAS, redirect/halt/ret-wait FSM
module pc_predict_unit
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_valid,
  input  logic [3:0]                 f_icode,
  input  logic [ADDR_W-1:0]          f_valC,
  input  logic [ADDR_W-1:0]          f_valP,
  input  logic                       stall,
  input  logic                       ex_redirect,
  input  logic [ADDR_W-1:0]          ex_target,
  output logic [ADDR_W-1:0]          pc,
  output logic                       halted,
  output logic                       ret_wait,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_ovf
);
  pcu_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ras_top;
  logic push, pop;
  pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(f_valP),
    .top(ras_top), .count(ras_count), .ovf(ras_ovf)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (ex_redirect && state_q != HALTED) begin
      pc_d    = ex_target;
      state_d = RUN;
    end else if (!stall && state_q == RUN && f_valid) begin
      case (f_icode)
        IJXX:  pc_d = f_valC;
        ICALL: begin
          pc_d = f_valC;
          push = 1'b1;
        end
        IRET:  if (ras_count != '0) begin
          pc_d = ras_top;
          pop  = 1'b1;
        end else state_d = RET_WAIT;
        IHALT: state_d = HALTED;
        default: if (f_icode > IPOPQ) state_d = HALTED; else pc_d = f_valP;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  assign pc       = pc_q;
  assign halted   = state_q == HALTED;
  assign ret_wait = state_q == RET_WAIT;
endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed self-checking bench for pc_predict_unit
module tb_pc_predict_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic f_valid = 1'b0, stall = 1'b0, ex_redirect = 1'b0;
  logic [3:0] f_icode = 4'h1;
  logic [63:0] f_valC = '0, f_valP = '0, ex_target = '0;
  logic [63:0] pc;
  logic halted, ret_wait, ras_ovf;
  logic [3:0] ras_count;
  int checks = 0, failures = 0;
  pc_predict_unit #(.ADDR_W(64), .RAS_DEPTH(8), .RESET_PC(64'h100)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_icode(f_icode), .f_valC(f_valC),
    .f_valP(f_valP), .stall(stall), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .pc(pc), .halted(halted), .ret_wait(ret_wait), .ras_count(ras_count), .ras_ovf(ras_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p,
                     input logic s, input logic r, input logic [63:0] t);
    f_valid = v; f_icode = ic; f_valC = c; f_valP = p; stall = s; ex_redirect = r; ex_target = t;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc; cyc;
    rst = 1'b0;
    chk("reset_pc", pc, 64'h100);
    chk("reset_halted", halted, 0);
    chk("reset_ret_wait", ret_wait, 0);
    chk("reset_count", ras_count, 0);
    chk("reset_ovf", ras_ovf, 0);
    drv(1, 4'h6, 64'h0, 64'h102, 0, 0, 0); cyc;
    chk("opq_valP", pc, 64'h102);
    drv(1, 4'h7, 64'h40, 64'h10B, 0, 0, 0); cyc;
    chk("jxx_valC", pc, 64'h40);
    drv(1, 4'h8, 64'h777, 64'h50, 1, 1, 64'h10A); cyc;
    chk("redirect_over_stall", pc, 64'h10A);
    chk("redirect_no_push", ras_count, 0);
    drv(1, 4'h8, 64'h777, 64'h50, 1, 0, 0); cyc;
    chk("stall_hold_pc", pc, 64'h10A);
    chk("stall_no_push", ras_count, 0);
    drv(0, 4'h6, 64'h0, 64'h999, 0, 0, 0); cyc;
    chk("invalid_hold", pc, 64'h10A);
    drv(1, 4'h8, 64'h200, 64'h109, 0, 0, 0); cyc;
    chk("call_pc", pc, 64'h200);
    chk("call_count", ras_count, 1);
    drv(1, 4'h9, 64'h0, 64'h201, 0, 0, 0); cyc;
    chk("ret_pc", pc, 64'h109);
    chk("ret_count", ras_count, 0);
    drv(1, 4'h9, 64'h0, 64'h10A, 0, 0, 0); cyc;
    chk("empty_ret_wait", ret_wait, 1);
    chk("empty_ret_pc", pc, 64'h109);
    drv(1, 4'h6, 64'h0, 64'h555, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc;
      chk("ret_wait_hold", pc, 64'h109);
      chk("ret_wait_state", ret_wait, 1);
    end
    drv(0, 4'h1, 0, 0, 0, 1, 64'h300); cyc;
    chk("ret_wait_redirect_pc", pc, 64'h300);
    chk("ret_wait_exit", ret_wait, 0);
    for (int i = 1; i <= 9; i++) begin
      drv(1, 4'h8, 64'h1000 + 64'(i), 64'(i), 0, 0, 0); cyc;
      chk("call_chain_pc", pc, 64'h1000 + 64'(i));
      if (i == 8) chk("full_no_ovf", ras_ovf, 0);
    end
    chk("ovf_set", ras_ovf, 1);
    chk("ovf_count", ras_count, 8);
    for (int k = 1; k <= 8; k++) begin
      drv(1, 4'h9, 0, 64'hDEAD, 0, 0, 0); cyc;
      chk("ret_chain_pc", pc, 64'(10 - k));
      chk("ret_chain_count", ras_count, 64'(8 - k));
    end
    chk("ovf_sticky", ras_ovf, 1);
    drv(1, 4'h8, 64'h600, 64'h60A, 0, 0, 0); cyc;
    chk("call2_pc", pc, 64'h600);
    drv(1, 4'h9, 0, 0, 1, 0, 0); cyc;
    chk("stall_ret_pc", pc, 64'h600);
    chk("stall_ret_count", ras_count, 1);
    drv(1, 4'h9, 0, 0, 0, 1, 64'h700); cyc;
    chk("redirect_ret_pc", pc, 64'h700);
    chk("redirect_no_pop", ras_count, 1);
    drv(1, 4'h9, 0, 0, 0, 0, 0); cyc;
    chk("ret2_pc", pc, 64'h60A);
    drv(1, 4'h0, 64'h11, 64'h22, 0, 0, 0); cyc;
    chk("halt_state", halted, 1);
    chk("halt_pc", pc, 64'h60A);
    drv(1, 4'h6, 0, 64'h33, 0, 1, 64'h500); cyc;
    chk("halt_ignore_redirect", pc, 64'h60A);
    chk("halt_stays", halted, 1);
    rst = 1'b1; cyc; rst = 1'b0;
    chk("rst2_pc", pc, 64'h100);
    chk("rst2_halted", halted, 0);
    chk("rst2_ovf", ras_ovf, 0);
    drv(1, 4'hC, 64'h44, 64'h55, 0, 0, 0); cyc;
    chk("bad_icode_halt", halted, 1);
    chk("bad_icode_pc", pc, 64'h100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Registered fetch-PC generator for the pipelined Y86 core; the parametrised successor to the single-cycle combinational PC update. It holds the architectural fetch PC, predicts the next PC from the instruction in fetch, and tracks call/return targets in a return-address stack (RAS). It accepts redirects from execute and enters halt/return-wait states. It sits between the fetch stage and the instruction memory address port.

## Interface
- ADDR_W, 64, PC/address width.
- RAS_DEPTH, 8, RAS entries (power of two, ≥2).
- RESET_PC, 0, PC value loaded on reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- f_valid  in  1  fetch inputs hold a valid instruction.
- f_icode  in  4  Y86 icode of fetched instruction.
- f_valC  in  ADDR_W  decoded constant (jump/call target).
- f_valP  in  ADDR_W  fall-through address.
- stall  in  1  hold PC and RAS this cycle.
- ex_redirect  in  1  execute detected misprediction.
- ex_target  in  ADDR_W  correct PC for the redirect.
- pc  out  ADDR_W  current fetch PC (registered).
- halted  out  1  HALTED state.
- ret_wait  out  1  RET_WAIT state.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  sticky: a push discarded an entry.

## Operation
- States: RUN, RET_WAIT, HALTED. Reset → RUN, pc=RESET_PC, ras_count=0, ras_ovf=0, halted=0, ret_wait=0.
- Per cycle, priority high→low: rst; ex_redirect; stall; prediction.
- ex_redirect (any state except HALTED): pc←ex_target, state→RUN; RAS unchanged (no checkpoint/repair). Overrides stall.
- stall without redirect: no state, pc or RAS change.
- Prediction in RUN with f_valid=1, keyed on f_icode:
  - 0x7 jXX: predict taken, pc←f_valC.
  - 0x8 call: pc←f_valC; push f_valP.
  - 0x9 ret, RAS non-empty: pc←top; pop.
  - 0x9 ret, RAS empty: pc holds; →RET_WAIT.
  - 0x0 halt, or f_icode>0xB: pc holds; →HALTED.
  - 0x1–0x6, 0xA, 0xB: pc←f_valP.
- f_valid=0 in RUN: pc holds.
- RET_WAIT: pc holds, fetch inputs ignored; exit only via ex_redirect or rst.
- HALTED: everything holds, ex_redirect ignored; exit only via rst.
- RAS is circular. Push at full overwrites the oldest entry: count stays RAS_DEPTH, ras_ovf←1 (cleared only by rst). Pop decrements count; wrap of the top pointer is modulo RAS_DEPTH.
- Arithmetic: no PC arithmetic in-block; all targets are supplied inputs. Counters do not wrap past 0 or RAS_DEPTH.

## Timing
- Latency 1: the decision made from cycle-N inputs appears on pc after edge N.
- Outputs are all registered; no combinational input→output path.
- A push and a pop never occur in the same cycle.
- ex_redirect together with a call/ret in fetch: the redirect wins, and no push or pop occurs.
- rst mid-operation (any state, any RAS fill) restores all reset values on the next edge.

## Structure
- Shared package `y86_pkg`: icode constants (IHALT=0 … IPOPQ=0xB, IJXX=7, ICALL=8, IRET=9) and the state enum `pcu_state_t`. Reuse these from the existing sequential blocks rather than duplicating them.
- One sub-module, `pc_ras` (params ADDR_W, RAS_DEPTH), providing push, pop, top, count and ovf. The top level holds the FSM and the pc register.

## Test plan
- Reset with RESET_PC=0x100 → pc=0x100, RUN, ras_count=0. Then opq with f_valP=0x102 → pc=0x102 next cycle.
- jXX (f_valC=0x40) → pc=0x40. Then ex_redirect with target 0x10A alongside stall=1 → pc=0x10A, stall ignored.
- call (valC=0x200, valP=0x109), then ret → pc=0x200, then 0x109; ras_count goes 1→0.
- ret with an empty RAS → ret_wait=1 and pc held for 3 cycles. ex_redirect to 0x300 → pc=0x300, RUN.
- RAS_DEPTH+1 calls with valP=1..9 (depth 8) → ras_ovf=1, count=8. Then 8 rets → pc=9,8,…,2, count=0.
- halt → halted=1, pc frozen, and ex_redirect ignored. rst → RUN, pc=RESET_PC, ras_ovf=0.
